// File: rtl/gpr_file.sv
// Triple-read, dual-write general-purpose register file. It zero-fills itself after reset
// (CLEAR), then accepts writes and reads normally (RUN). Same-address dual writes are counted.
module gpr_file #(
    parameter int   NUM_REGS = 32,
    parameter int   WIDTH    = 32,
    parameter logic BYPASS   = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(NUM_REGS)-1:0] ra_sel,
    input  logic [$clog2(NUM_REGS)-1:0] rb_sel,
    input  logic [$clog2(NUM_REGS)-1:0] rc_sel,
    output logic [WIDTH-1:0]            ra,
    output logic [WIDTH-1:0]            rb,
    output logic [WIDTH-1:0]            rc,
    input  logic [$clog2(NUM_REGS)-1:0] wa_sel,
    input  logic [$clog2(NUM_REGS)-1:0] wb_sel,
    input  logic [WIDTH-1:0]            wa,
    input  logic [WIDTH-1:0]            wb,
    input  logic                        wa_wr,
    input  logic                        wb_wr,
    output logic                        ready,
    output logic                        conflict,
    output logic [7:0]                  conflict_cnt
);
    localparam int AW = $clog2(NUM_REGS);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic            ready_q, ready_d;
    logic            conflict_q, conflict_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem [NUM_REGS];

    logic run, wa_en, wb_en;
    logic [AW-1:0]    rsel  [3];
    logic [WIDTH-1:0] rdata [3];

    assign run   = (state_q == RUN);
    assign wa_en = run && wa_wr;
    assign wb_en = run && wb_wr;

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        conflict_d = wa_en && wb_en && (wa_sel == wb_sel);
        cnt_d      = cnt_q;
        if (conflict_d && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
        if (!run) begin
            clr_ptr_d = clr_ptr_q + AW'(1);
            if (clr_ptr_q == AW'(NUM_REGS - 1))
                state_d = RUN;
        end
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            ready_q    <= 1'b0;
            conflict_q <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            ready_q    <= ready_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage is deliberately not reset; CLEAR walks it to zero instead.
    // Port a is written last so it wins a same-address dual write.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_ptr_q] <= '0;
        end else begin
            if (wb_en) mem[wb_sel] <= wb;
            if (wa_en) mem[wa_sel] <= wa;
        end
    end

    assign rsel[0] = ra_sel;
    assign rsel[1] = rb_sel;
    assign rsel[2] = rc_sel;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rdata[p] = mem[rsel[p]];
            if (BYPASS) begin
                if (wa_en && wa_sel == rsel[p])
                    rdata[p] = wa;
                else if (wb_en && wb_sel == rsel[p])
                    rdata[p] = wb;
            end
            if (!run)
                rdata[p] = '0;
        end
    end

    assign ra           = rdata[0];
    assign rb           = rdata[1];
    assign rc           = rdata[2];
    assign ready        = ready_q;
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_gpr_file.sv
// Scoreboard bench for gpr_file: expected read data is queued when stimulus is driven
// and popped when the outputs are sampled on the falling edge.
module tb_gpr_file;
    logic        clk, reset;
    logic [4:0]  ra_sel, rb_sel, rc_sel, wa_sel, wb_sel;
    logic [31:0] ra, rb, rc, wa, wb;
    logic        wa_wr, wb_wr, ready, conflict;
    logic [7:0]  conflict_cnt;

    logic [31:0] sb_q [$];
    logic [31:0] model [32];
    logic [31:0] rd_bus [3];
    int          exp_cnt;
    int          errors = 0;
    int          checks = 0;

    gpr_file #(.NUM_REGS(32), .WIDTH(32), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .ra_sel(ra_sel), .rb_sel(rb_sel), .rc_sel(rc_sel),
        .ra(ra), .rb(rb), .rc(rc),
        .wa_sel(wa_sel), .wb_sel(wb_sel), .wa(wa), .wb(wb),
        .wa_wr(wa_wr), .wb_wr(wb_wr),
        .ready(ready), .conflict(conflict), .conflict_cnt(conflict_cnt)
    );

    assign rd_bus[0] = ra;
    assign rd_bus[1] = rb;
    assign rd_bus[2] = rc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] s);
        if (wa_wr && wa_sel == s) return wa;
        if (wb_wr && wb_sel == s) return wb;
        return model[s];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_cnt = 0;
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic writes_off();
        wa_wr = 1'b0;
        wb_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ra_sel = 5'd5; rb_sel = 5'd0; rc_sel = 5'd31;
        sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        #3;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got=%b exp=0", conflict); end
        checks++; if (conflict_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", conflict_cnt); end
        for (int p = 0; p < 3; p++) begin
            logic [31:0] e;
            e = sb_q.pop_front();
            checks++;
            if (rd_bus[p] !== e) begin errors++; $display("FAIL reset_read port%0d got=%h exp=%h", p, rd_bus[p], e); end
        end
    endtask

    // Release reset with a dual same-address write held during CLEAR: it must be ignored.
    task automatic test_clear_sequence();
        int n;
        logic saw_conflict;
        align();
        reset = 1'b0;
        wa_wr = 1'b1; wa_sel = 5'd5; wa = 32'hDEADBEEF;
        wb_wr = 1'b1; wb_sel = 5'd5; wb = 32'h0BADF00D;
        model_clear();
        n = 0;
        saw_conflict = 1'b0;
        do begin
            align();
            n++;
            if (conflict) saw_conflict = 1'b1;
        end while (!ready && n < 100);
        writes_off();
        checks++; if (n !== 32) begin errors++; $display("FAIL clear_latency got=%0d edges exp=32", n); end
        checks++; if (saw_conflict !== 1'b0) begin errors++; $display("FAIL clear_conflict got=%b exp=0", saw_conflict); end
        checks++; if (conflict_cnt !== 8'd0) begin errors++; $display("FAIL clear_cnt got=%0d exp=0", conflict_cnt); end
        for (int i = 0; i < 32; i++) begin
            ra_sel = 5'(i); rb_sel = 5'(31 - i); rc_sel = 5'd5;
            sb_q.push_back(exp_rd(ra_sel)); sb_q.push_back(exp_rd(rb_sel)); sb_q.push_back(exp_rd(rc_sel));
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                logic [31:0] e;
                e = sb_q.pop_front();
                checks++;
                if (rd_bus[p] !== e) begin errors++; $display("FAIL clear_read i=%0d port%0d got=%h exp=%h", i, p, rd_bus[p], e); end
            end
        end
    endtask

    task automatic test_bypass();
        align();
        wa_wr = 1'b1; wa_sel = 5'd3; wa = 32'h12345678;
        wb_wr = 1'b1; wb_sel = 5'd4; wb = 32'hCAFEF00D;
        ra_sel = 5'd3; rb_sel = 5'd4; rc_sel = 5'd3;
        sb_q.push_back(32'h12345678); sb_q.push_back(32'hCAFEF00D); sb_q.push_back(32'h12345678);
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            logic [31:0] e;
            e = sb_q.pop_front();
            checks++;
            if (rd_bus[p] !== e) begin errors++; $display("FAIL bypass_same_cycle port%0d got=%h exp=%h", p, rd_bus[p], e); end
        end
        model[3] = 32'h12345678;
        model[4] = 32'hCAFEF00D;
        align();
        writes_off();
        ra_sel = 5'd4; rb_sel = 5'd3; rc_sel = 5'd0;
        sb_q.push_back(32'hCAFEF00D); sb_q.push_back(32'h12345678); sb_q.push_back(32'h0);
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            logic [31:0] e;
            e = sb_q.pop_front();
            checks++;
            if (rd_bus[p] !== e) begin errors++; $display("FAIL bypass_next_cycle port%0d got=%h exp=%h", p, rd_bus[p], e); end
        end
    endtask

    task automatic test_conflict();
        align();
        wa_wr = 1'b1; wb_wr = 1'b1; wa_sel = 5'd7; wb_sel = 5'd7; wa = 32'h1; wb = 32'h2;
        ra_sel = 5'd7; rb_sel = 5'd7; rc_sel = 5'd0;
        sb_q.push_back(32'h1); sb_q.push_back(32'h1); sb_q.push_back(32'h0);
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            logic [31:0] e;
            e = sb_q.pop_front();
            checks++;
            if (rd_bus[p] !== e) begin errors++; $display("FAIL conflict_bypass port%0d got=%h exp=%h", p, rd_bus[p], e); end
        end
        model[7] = 32'h1;
        exp_cnt = 1;
        align();
        writes_off();
        checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL conflict_pulse got=%b exp=1", conflict); end
        checks++; if (conflict_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL conflict_cnt got=%0d exp=%0d", conflict_cnt, exp_cnt); end
        ra_sel = 5'd7;
        sb_q.push_back(32'h1);
        @(negedge clk);
        begin
            logic [31:0] e;
            e = sb_q.pop_front();
            checks++;
            if (ra !== e) begin errors++; $display("FAIL conflict_r7 got=%h exp=%h", ra, e); end
        end
        align();
        checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL conflict_pulse_end got=%b exp=0", conflict); end
    endtask

    task automatic test_saturate();
        logic [31:0] last;
        align();
        wa_wr = 1'b1; wb_wr = 1'b1; wa_sel = 5'd7; wb_sel = 5'd7; wa = 32'h0; wb = 32'hFFFF_0000;
        last = 32'h0;
        for (int k = 1; k <= 300; k++) begin
            align();
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL sat_pulse k=%0d got=%b exp=1", k, conflict); end
            checks++; if (conflict_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, conflict_cnt, exp_cnt); end
            if (k < 300) begin
                wa = 32'(k);
                last = wa;
            end else begin
                writes_off();
            end
        end
        model[7] = last;
        ra_sel = 5'd7;
        sb_q.push_back(model[7]);
        @(negedge clk);
        begin
            logic [31:0] e;
            e = sb_q.pop_front();
            checks++;
            if (ra !== e) begin errors++; $display("FAIL sat_r7 got=%h exp=%h", ra, e); end
        end
        align();
        checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL sat_pulse_end got=%b exp=0", conflict); end
        checks++; if (conflict_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got=%0d exp=255", conflict_cnt); end
    endtask

    task automatic test_back_to_back();
        logic exp_conf;
        exp_conf = 1'b0;
        for (int k = 0; k < 60; k++) begin
            align();
            if (k > 0) begin
                checks++; if (conflict !== exp_conf) begin errors++; $display("FAIL b2b_conflict k=%0d got=%b exp=%b", k, conflict, exp_conf); end
                checks++; if (conflict_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt k=%0d got=%0d exp=%0d", k, conflict_cnt, exp_cnt); end
            end
            wa_wr = 1'($urandom_range(0, 1)); wb_wr = 1'($urandom_range(0, 1));
            wa_sel = 5'($urandom_range(0, 7)); wb_sel = 5'($urandom_range(0, 7));
            wa = $urandom; wb = $urandom;
            ra_sel = 5'($urandom_range(0, 7)); rb_sel = 5'($urandom_range(0, 7)); rc_sel = 5'($urandom_range(0, 7));
            sb_q.push_back(exp_rd(ra_sel)); sb_q.push_back(exp_rd(rb_sel)); sb_q.push_back(exp_rd(rc_sel));
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                logic [31:0] e;
                e = sb_q.pop_front();
                checks++;
                if (rd_bus[p] !== e) begin errors++; $display("FAIL b2b_read k=%0d port%0d got=%h exp=%h", k, p, rd_bus[p], e); end
            end
            if (wb_wr) model[wb_sel] = wb;
            if (wa_wr) model[wa_sel] = wa;
            exp_conf = wa_wr && wb_wr && (wa_sel == wb_sel);
            if (exp_conf && exp_cnt < 255) exp_cnt++;
        end
        align();
        writes_off();
        checks++; if (conflict !== exp_conf) begin errors++; $display("FAIL b2b_conflict_last got=%b exp=%b", conflict, exp_conf); end
    endtask

    task automatic test_reset_in_run();
        int n;
        align();
        wa_wr = 1'b1; wa_sel = 5'd9; wa = 32'hAA;
        align();
        writes_off();
        model[9] = 32'hAA;
        ra_sel = 5'd9;
        sb_q.push_back(model[9]);
        @(negedge clk);
        begin
            logic [31:0] e;
            e = sb_q.pop_front();
            checks++;
            if (ra !== e) begin errors++; $display("FAIL run_r9_before got=%h exp=%h", ra, e); end
        end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL run_rst_ready got=%b exp=0", ready); end
        checks++; if (conflict_cnt !== 8'd0) begin errors++; $display("FAIL run_rst_cnt got=%0d exp=0", conflict_cnt); end
        align();
        reset = 1'b0;
        model_clear();
        n = 0;
        do begin align(); n++; end while (!ready && n < 100);
        checks++; if (n !== 32) begin errors++; $display("FAIL run_rst_latency got=%0d edges exp=32", n); end
        ra_sel = 5'd9; rb_sel = 5'd7; rc_sel = 5'd3;
        sb_q.push_back(model[9]); sb_q.push_back(model[7]); sb_q.push_back(model[3]);
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            logic [31:0] e;
            e = sb_q.pop_front();
            checks++;
            if (rd_bus[p] !== e) begin errors++; $display("FAIL run_rst_read port%0d got=%h exp=%h", p, rd_bus[p], e); end
        end
    endtask

    task automatic test_reset_in_clear();
        int n;
        align();
        reset = 1'b1;
        align();
        reset = 1'b0;
        repeat (10) align();
        reset = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL clr_rst_ready got=%b exp=0", ready); end
        align();
        reset = 1'b0;
        model_clear();
        n = 0;
        do begin align(); n++; end while (!ready && n < 100);
        checks++; if (n !== 32) begin errors++; $display("FAIL clr_rst_latency got=%0d edges exp=32", n); end
        ra_sel = 5'd9; rb_sel = 5'd31; rc_sel = 5'd0;
        sb_q.push_back(model[9]); sb_q.push_back(model[31]); sb_q.push_back(model[0]);
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            logic [31:0] e;
            e = sb_q.pop_front();
            checks++;
            if (rd_bus[p] !== e) begin errors++; $display("FAIL clr_rst_read port%0d got=%h exp=%h", p, rd_bus[p], e); end
        end
    endtask

    initial begin
        reset = 1'b1;
        wa_wr = 1'b0; wb_wr = 1'b0;
        wa_sel = '0; wb_sel = '0; wa = '0; wb = '0;
        ra_sel = '0; rb_sel = '0; rc_sel = '0;
        model_clear();
        test_reset();
        test_clear_sequence();
        test_bypass();
        test_conflict();
        test_saturate();
        test_back_to_back();
        test_reset_in_run();
        test_reset_in_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
